// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: fetch-side inputs, hazard/CP0 controls, write-back port and D-stage outputs.
interface decode_stage_pipe_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          StallD;
  logic          FlushD;
  logic          ReqExc;
  logic [DW-1:0] InstrF;
  logic [DW-1:0] PCF;
  logic [4:0]    ExcCodeF;
  logic          BDF;
  logic          RIDec;
  logic [AW-1:0] A3W;
  logic [DW-1:0] WDW;
  logic [DW-1:0] PCW;
  logic [DW-1:0] ForwardD1;
  logic [DW-1:0] ForwardD2;
  logic [DW-1:0] InstrD;
  logic [DW-1:0] PCD;
  logic [DW-1:0] PC4D;
  logic          BDD;
  logic [DW-1:0] RD1D;
  logic [DW-1:0] RD2D;
  logic [4:0]    ExcCodeDE;
  logic          EqualD;
  logic          LTZD;
  logic          EQZD;

  modport master (
    output StallD, FlushD, ReqExc, InstrF, PCF, ExcCodeF, BDF, RIDec,
           A3W, WDW, PCW, ForwardD1, ForwardD2,
    input  InstrD, PCD, PC4D, BDD, RD1D, RD2D, ExcCodeDE, EqualD, LTZD, EQZD
  );

  modport slave (
    input  StallD, FlushD, ReqExc, InstrF, PCF, ExcCodeF, BDF, RIDec,
           A3W, WDW, PCW, ForwardD1, ForwardD2,
    output InstrD, PCD, PC4D, BDD, RD1D, RD2D, ExcCodeDE, EqualD, LTZD, EQZD
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// MIPS decode stage: IF/ID register, GRF, RI exception tag and branch comparator.
// Define GRF_BYPASS_EN to make same-cycle GRF writes visible on RD1D/RD2D.
module decode_stage_pipe #(
  parameter int          DW       = 32,
  parameter int          AW       = 5,
  parameter int          NREG     = 32,
  parameter logic [DW-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [DW-1:0] EXC_PC   = 32'h0000_4180
) (
  input  logic               clk_i,
  input  logic               rst_i,
  decode_stage_pipe_if.slave bus
);

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
    logic [4:0]    exc;
    logic          bd;
  } ifid_t;

  ifid_t ifid_q, ifid_d;

  // ReqExc beats a stall; a stall swallows a concurrent FlushD.
  always_comb begin
    ifid_d = ifid_q;
    if (bus.ReqExc)
      ifid_d = '{instr: '0, pc: EXC_PC, exc: '0, bd: 1'b0};
    else if (bus.StallD)
      ifid_d = ifid_q;
    else if (bus.FlushD)
      ifid_d = '{instr: '0, pc: bus.PCF, exc: '0, bd: 1'b0};
    else
      ifid_d = '{instr: bus.InstrF, pc: bus.PCF, exc: bus.ExcCodeF, bd: bus.BDF};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ifid_q <= '{instr: '0, pc: RESET_PC, exc: '0, bd: 1'b0};
    else       ifid_q <= ifid_d;
  end

  // Entry 0 is never stored; it reads as zero through the default below.
  logic [DW-1:0] grf_q [1:NREG-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < NREG; i++) grf_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (int'(bus.A3W) == i) grf_q[i] <= bus.WDW;
    end
  end

  logic [AW-1:0] rs, rt;
  logic [DW-1:0] rd1, rd2;

  assign rs = AW'(ifid_q.instr[25:21]);
  assign rt = AW'(ifid_q.instr[20:16]);

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NREG; i++) begin
      if (int'(rs) == i) rd1 = grf_q[i];
      if (int'(rt) == i) rd2 = grf_q[i];
    end
`ifdef GRF_BYPASS_EN
    if (bus.A3W != '0 && int'(bus.A3W) < NREG) begin
      if (bus.A3W == rs) rd1 = bus.WDW;
      if (bus.A3W == rt) rd2 = bus.WDW;
    end
`endif
  end

  // PCW only feeds the simulation write log kept outside the design.
  logic unused_pcw;
  assign unused_pcw = ^bus.PCW;

  assign bus.InstrD    = ifid_q.instr;
  assign bus.PCD       = ifid_q.pc;
  assign bus.PC4D      = ifid_q.pc + DW'(4);
  assign bus.BDD       = ifid_q.bd;
  assign bus.RD1D      = rd1;
  assign bus.RD2D      = rd2;
  assign bus.ExcCodeDE = (bus.RIDec && ifid_q.exc == 5'd0) ? 5'd10 : ifid_q.exc;
  assign bus.EqualD    = (bus.ForwardD1 == bus.ForwardD2);
  assign bus.LTZD      = bus.ForwardD1[DW-1];
  assign bus.EQZD      = (bus.ForwardD1 == '0);

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: directed test-plan cycles then random traffic.
module tb_decode_stage_pipe;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;
`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_pipe_if #(.DW(DW), .AW(AW)) bus ();

  decode_stage_pipe #(
    .DW(DW), .AW(AW), .NREG(NREG),
    .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] instr, pc, pc4, rd1, rd2;
    logic        bd, eq, ltz, eqz;
    logic [4:0]  exc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Reference state: D-stage fields and register file contents
  logic [31:0] m_instr, m_pc;
  logic [4:0]  m_exc;
  logic        m_bd;
  logic [31:0] m_grf [NREG];

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= NREG) return 32'h0;
    if (BYP && bus.A3W == idx) return bus.WDW;
    return m_grf[idx];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_instr = 0; m_pc = 32'h3000; m_exc = 0; m_bd = 0;
      foreach (m_grf[i]) m_grf[i] = 0;
    end else begin
      if (bus.A3W != 0 && int'(bus.A3W) < NREG) m_grf[bus.A3W] = bus.WDW;
      if (bus.ReqExc) begin
        m_instr = 0; m_pc = 32'h4180; m_exc = 0; m_bd = 0;
      end else if (bus.StallD) begin
        // hold
      end else if (bus.FlushD) begin
        m_instr = 0; m_pc = bus.PCF; m_exc = 0; m_bd = 0;
      end else begin
        m_instr = bus.InstrF; m_pc = bus.PCF; m_exc = bus.ExcCodeF; m_bd = bus.BDF;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic re, input logic st, input logic fl,
                     input logic [31:0] instr, input logic [31:0] pc,
                     input logic [4:0] ef, input logic bf, input logic ri,
                     input logic [4:0] a3, input logic [31:0] wd,
                     input logic [31:0] f1, input logic [31:0] f2);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; bus.ReqExc = re; bus.StallD = st; bus.FlushD = fl;
    bus.InstrF = instr; bus.PCF = pc; bus.ExcCodeF = ef; bus.BDF = bf;
    bus.RIDec = ri; bus.A3W = a3; bus.WDW = wd; bus.PCW = pc - 32'h10;
    bus.ForwardD1 = f1; bus.ForwardD2 = f2;
    e.instr = m_instr;
    e.pc    = m_pc;
    e.pc4   = m_pc + 32'd4;
    e.bd    = m_bd;
    e.rd1   = m_read(m_instr[25:21]);
    e.rd2   = m_read(m_instr[20:16]);
    e.exc   = (m_exc != 0) ? m_exc : (ri ? 5'd10 : 5'd0);
    e.eq    = (f1 == f2);
    e.ltz   = f1[31];
    e.eqz   = (f1 == 0);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, req, $time);
  endtask

  // Monitor: compares DUT outputs against the oldest expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("InstrD",    bus.InstrD,           e.instr);
        chk("PCD",       bus.PCD,              e.pc);
        chk("PC4D",      bus.PC4D,             e.pc4);
        chk("BDD",       32'(bus.BDD),         32'(e.bd));
        chk("RD1D",      bus.RD1D,             e.rd1);
        chk("RD2D",      bus.RD2D,             e.rd2);
        chk("ExcCodeDE", 32'(bus.ExcCodeDE),   32'(e.exc));
        chk("EqualD",    32'(bus.EqualD),      32'(e.eq));
        chk("LTZD",      32'(bus.LTZD),        32'(e.ltz));
        chk("EQZD",      32'(bus.EQZD),        32'(e.eqz));
      end
    end
  end

  // Simulation write log
  always @(posedge clk)
    if (!rst && bus.A3W != 0 && int'(bus.A3W) < NREG)
      $display("@%08h: $%0d <= %08h", bus.PCW, bus.A3W, bus.WDW);

  initial begin
    logic [31:0] instr, f1, f2;
    logic [4:0]  a3, ef;
    rst = 1'b1;
    bus.StallD = 0; bus.FlushD = 0; bus.ReqExc = 0; bus.InstrF = 0; bus.PCF = 0;
    bus.ExcCodeF = 0; bus.BDF = 0; bus.RIDec = 0; bus.A3W = 0; bus.WDW = 0;
    bus.PCW = 0; bus.ForwardD1 = 0; bus.ForwardD2 = 0;

    // reset, then hold idle
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load then stall with changing InstrF, then stall+flush
    cyc(0, 0, 0, 0, 32'h3C01_1234, 32'h3004, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h1111_1111, 32'h3008, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h2222_2222, 32'h300C, 2, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h3333_3333, 32'h3010, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h4444_4444, 32'h3014, 0, 0, 0, 0, 0, 0, 0);
    // flush, observe, then ReqExc together with stall
    cyc(0, 0, 0, 1, 32'hAAAA_AAAA, 32'h3010, 3, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 32'h5555_5555, 32'h3014, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 32'h6666_6666, 32'h3018, 0, 0, 0, 0, 0, 0, 0);
    // rs=5, rt=6 in D; write $5 while reading it
    cyc(0, 0, 0, 0, 32'h00A6_0000, 32'h3020, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 5'd5, 32'hDEAD_BEEF, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 5'd0, 32'h1234_5678, 0, 0);
    // $0 reads stay zero even with A3W=0 data floating
    cyc(0, 0, 0, 0, 32'h0000_0000, 32'h3024, 0, 0, 0, 5'd0, 32'hFFFF_FFFF, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0);
    // fetch exception has precedence over RI
    cyc(0, 0, 0, 0, 32'h1234_5678, 32'h3028, 5'd4, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h8000_0000, 32'h8000_0000);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h5);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      instr = $urandom;
      ef = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      case ($urandom_range(0, 3))
        0: a3 = m_instr[25:21];
        1: a3 = m_instr[20:16];
        default: a3 = 5'($urandom_range(0, 31));
      endcase
      case ($urandom_range(0, 3))
        0: f1 = 32'h0;
        1: f1 = 32'h8000_0000 | $urandom;
        default: f1 = $urandom;
      endcase
      f2 = ($urandom_range(0, 2) == 0) ? f1 : $urandom;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          instr, $urandom & 32'hFFFF_FFFC, ef, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), a3, $urandom, f1, f2);
    end

    // drain with a bounded wait
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
